// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse-cipher round-key generator: forward-expands to round 10, then steps back one round per next_i.
// Optional build macro AES_INV_KEY_LAST_LOAD_EN adds key_is_last_i to load a round-10 key directly.
//
// state  | meaning
// IDLE   | no valid key, waiting for load
// EXPAND | forward expansion from cipher key toward round 10
// READY  | round_key_o valid, next_i steps back toward round 0
module aes_inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [127:0] key_i,
`ifdef AES_INV_KEY_LAST_LOAD_EN
  input  logic         key_is_last_i,
`endif
  input  logic         next_i,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_idx_o,
  output logic         key_valid_o,
  output logic         busy_o
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  state_e       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         load_last;

`ifdef AES_INV_KEY_LAST_LOAD_EN
  assign load_last = load_i & key_is_last_i;
`else
  assign load_last = 1'b0;
`endif

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w3_prev, sub_in, rot, sub_out, t_word;
  logic [3:0]  rcon_idx;
  logic [127:0] fwd_key, inv_key;

  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];
  assign w3_prev = w3 ^ w2;

  // One S-box bank serves both directions; only one is used in any given state.
  assign sub_in   = (state_q == EXPAND) ? w3 : w3_prev;
  assign rcon_idx = (state_q == EXPAND) ? round_idx_q + 4'd1 : round_idx_q;
  assign rot      = {sub_in[23:0], sub_in[31:24]};
  assign sub_out  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign t_word   = sub_out ^ {rcon(rcon_idx), 24'h0};

  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0 = w0 ^ t_word;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    fwd_key = {n0, n1, n2, n3};
    inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3_prev};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_last ? READY : EXPAND;
    end else begin
      case (state_q)
        EXPAND:  if (round_idx_q == LAST_RND - 4'd1) state_d = READY;
        READY:   if (next_i && round_idx_q == 4'd0) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    key_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      EXPAND:  busy_o      = 1'b1;
      READY:   key_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    if (load_i) begin
      round_key_d = key_i;
      round_idx_d = load_last ? LAST_RND : 4'd0;
    end else if (state_q == EXPAND) begin
      round_key_d = fwd_key;
      round_idx_d = round_idx_q + 4'd1;
    end else if (state_q == READY && next_i && round_idx_q != 4'd0) begin
      round_key_d = inv_key;
      round_idx_d = round_idx_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      round_key_q <= '0;
      round_idx_q <= '0;
    end else begin
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
    end
  end

  assign round_key_o = round_key_q;
  assign round_idx_o = round_idx_q;

endmodule
